// File: rtl/gp_cmd_executor.sv
// Command executor: fetches 64-bit commands from cmd_buffer and issues WRITE / read-modify-write bus transfers.
// Optional bus-stall timeout is compiled in when GP_EXEC_TIMEOUT_EN is defined.
module gp_cmd_executor #(
   parameter int CMD_WIDTH      = 64,
   parameter int CMD_DEPTH      = 128,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  cmd_rd_en,
   output logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic                  cmd_rd_valid,
   input  logic [CMD_WIDTH-1:0]  cmd_out,
   output logic                  mst_o_valid,
   output logic [ADDR_WIDTH-1:0] mst_o_addr,
   output logic [DATA_WIDTH-1:0] mst_o_wr_data,
   output logic                  mst_o_rd0_wr1,
   input  logic                  mst_i_ready,
   input  logic [DATA_WIDTH-1:0] mst_i_rd_data,
   input  logic                  mst_i_rd_valid,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_WAIT_CMD, S_DECODE, S_WR, S_RD,
      S_RD_WAIT, S_MOD_WR, S_NEXT, S_DONE
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(CMD_DEPTH - 1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
   logic                  cmd_rd_en_q, cmd_rd_en_d;
   logic                  valid_q, valid_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                  rd0_wr1_q, rd0_wr1_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic [1:0]            opcode;
   logic [DATA_WIDTH-1:0] cmd_data;
   logic [ADDR_WIDTH-1:0] cmd_byte_addr;
   logic                  handshake;

   assign opcode        = cmd_q[1:0];
   assign cmd_data      = cmd_q[DATA_WIDTH+1:2];
   assign cmd_byte_addr = {cmd_q[CMD_WIDTH-1:DATA_WIDTH+2], 2'b00};
   assign handshake     = valid_q && mst_i_ready;

`ifdef GP_EXEC_TIMEOUT_EN
   localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [STALL_W-1:0] stall_q, stall_d;
`endif

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cmd_d       = cmd_q;
      cmd_rd_en_d = 1'b0;
      valid_d     = valid_q;
      addr_d      = addr_q;
      wr_data_d   = wr_data_q;
      rd0_wr1_d   = rd0_wr1_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = err_q;
`ifdef GP_EXEC_TIMEOUT_EN
      stall_d     = '0;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_FETCH;
               idx_d       = '0;
               cmd_rd_en_d = 1'b1;
               busy_d      = 1'b1;
               err_d       = 1'b0;
            end
         end
         S_FETCH: state_d = S_WAIT_CMD;
         S_WAIT_CMD: begin
            if (cmd_rd_valid) begin
               cmd_d   = cmd_out;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            case (opcode)
               2'b00: begin
                  state_d   = S_WR;
                  valid_d   = 1'b1;
                  addr_d    = cmd_byte_addr;
                  wr_data_d = cmd_data;
                  rd0_wr1_d = 1'b1;
               end
               2'b01: begin
                  state_d   = S_RD;
                  valid_d   = 1'b1;
                  addr_d    = cmd_byte_addr;
                  rd0_wr1_d = 1'b0;
               end
               2'b11: begin
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
               default: begin
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end
            endcase
         end
         S_WR: begin
            if (handshake) begin
               valid_d = 1'b0;
               state_d = S_NEXT;
            end
         end
         // Read data arriving with the acceptance skips RD_WAIT entirely.
         S_RD: begin
            if (handshake) begin
               valid_d = 1'b0;
               if (mst_i_rd_valid) begin
                  wr_data_d = mst_i_rd_data | cmd_data;
                  rd0_wr1_d = 1'b1;
                  state_d   = S_MOD_WR;
               end else begin
                  state_d = S_RD_WAIT;
               end
            end
         end
         S_RD_WAIT: begin
            if (mst_i_rd_valid) begin
               wr_data_d = mst_i_rd_data | cmd_data;
               rd0_wr1_d = 1'b1;
               state_d   = S_MOD_WR;
            end
         end
         S_MOD_WR: begin
            if (!valid_q) begin
               valid_d = 1'b1;
            end else if (mst_i_ready) begin
               valid_d = 1'b0;
               state_d = S_NEXT;
            end
         end
         S_NEXT: begin
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               idx_d       = idx_q + 1'b1;
               cmd_rd_en_d = 1'b1;
               state_d     = S_FETCH;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
`ifdef GP_EXEC_TIMEOUT_EN
      // The stall timeout overrides whatever the bus states decided this cycle.
      if (state_q inside {S_WR, S_RD, S_RD_WAIT, S_MOD_WR}) begin
         if (handshake) begin
            stall_d = '0;
         end else if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
            stall_d = '0;
            valid_d = 1'b0;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
         end else begin
            stall_d = stall_q + 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         cmd_q       <= '0;
         cmd_rd_en_q <= 1'b0;
         valid_q     <= 1'b0;
         addr_q      <= '0;
         wr_data_q   <= '0;
         rd0_wr1_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
`ifdef GP_EXEC_TIMEOUT_EN
         stall_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cmd_q       <= cmd_d;
         cmd_rd_en_q <= cmd_rd_en_d;
         valid_q     <= valid_d;
         addr_q      <= addr_d;
         wr_data_q   <= wr_data_d;
         rd0_wr1_q   <= rd0_wr1_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
`ifdef GP_EXEC_TIMEOUT_EN
         stall_q     <= stall_d;
`endif
      end
   end

   assign cmd_rd_en     = cmd_rd_en_q;
   assign cmd_addr      = idx_q;
   assign mst_o_valid   = valid_q;
   assign mst_o_addr    = addr_q;
   assign mst_o_wr_data = wr_data_q;
   assign mst_o_rd0_wr1 = rd0_wr1_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;

endmodule
